// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet header (0..W bytes) from the front of an AXI-Stream packet,
// reports it on a side strobe and realigns the remaining payload to MSB-first beats.
module axi_stream_strip_header #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          data_in,
   input  logic [KEEP_WIDTH-1:0]          keep_in,
   input  logic                           last_in,
   input  logic                           valid_in,
   output logic                           ready_in,
   input  logic [$clog2(KEEP_WIDTH):0]    hdr_len,
   output logic [DATA_WIDTH-1:0]          hdr_data,
   output logic [KEEP_WIDTH-1:0]          hdr_keep,
   output logic                           hdr_valid,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic [KEEP_WIDTH-1:0]          keep_out,
   output logic                           last_out,
   output logic                           valid_out,
   input  logic                           ready_out
);

   localparam int unsigned W  = KEEP_WIDTH;
   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned CW = $clog2(KEEP_WIDTH) + 1;
   localparam int unsigned TW = CW + 1;

   typedef enum logic [1:0] {ST_HDR, ST_BODY, ST_FLUSH} state_t;

   // Byte-enable mask with the top cnt bytes set (first cnt bytes in stream order)
   function automatic logic [W-1:0] top_ones(input logic [CW-1:0] cnt);
      top_ones = ~({W{1'b1}} >> cnt);
   endfunction

   function automatic logic [DW-1:0] expand(input logic [W-1:0] k);
      expand = '0;
      for (int i = 0; i < int'(W); i++) expand[i*8 +: 8] = {8{k[i]}};
   endfunction

   function automatic logic [CW-1:0] popcnt(input logic [W-1:0] k);
      popcnt = '0;
      for (int i = 0; i < int'(W); i++) popcnt = popcnt + CW'(k[i]);
   endfunction

   state_t          state, state_nxt;
   logic [DW-1:0]   res_data, res_data_nxt;
   logic [CW-1:0]   res_cnt, res_cnt_nxt;
   logic [DW-1:0]   data_out_nxt, hdr_data_nxt;
   logic [W-1:0]    keep_out_nxt, hdr_keep_nxt;
   logic            last_out_nxt, valid_out_nxt, hdr_valid_nxt;

   logic            accept;
   logic [CW-1:0]   n_in, s_in;
   logic [DW-1:0]   data_m, first_rest;
   logic [2*DW-1:0] joined;
   logic [TW-1:0]   total;
   logic [W-1:0]    hdr_mask;

   assign ready_in = rst & (~valid_out | ready_out) & (state != ST_FLUSH);
   assign accept   = valid_in & ready_in;

   // Beat decode: byte count, masked data, clamped header length
   assign n_in       = popcnt(keep_in);
   assign data_m     = data_in & expand(keep_in);
   assign s_in       = (hdr_len > CW'(W)) ? CW'(W) : hdr_len;
   assign hdr_mask   = keep_in & top_ones(s_in);
   assign first_rest = data_m << {s_in, 3'b000};

   // Residual bytes followed by the new beat's bytes, MSB-first across 2W bytes
   assign joined = {res_data, {DW{1'b0}}} | ({data_m, {DW{1'b0}}} >> {res_cnt, 3'b000});
   assign total  = TW'(res_cnt) + TW'(n_in);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_HDR;
         res_data  <= '0;
         res_cnt   <= '0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
         valid_out <= 1'b0;
         hdr_data  <= '0;
         hdr_keep  <= '0;
         hdr_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         res_data  <= res_data_nxt;
         res_cnt   <= res_cnt_nxt;
         data_out  <= data_out_nxt;
         keep_out  <= keep_out_nxt;
         last_out  <= last_out_nxt;
         valid_out <= valid_out_nxt;
         hdr_data  <= hdr_data_nxt;
         hdr_keep  <= hdr_keep_nxt;
         hdr_valid <= hdr_valid_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      res_data_nxt  = res_data;
      res_cnt_nxt   = res_cnt;
      data_out_nxt  = data_out;
      keep_out_nxt  = keep_out;
      last_out_nxt  = last_out;
      valid_out_nxt = valid_out & ~ready_out;
      hdr_data_nxt  = hdr_data;
      hdr_keep_nxt  = hdr_keep;
      hdr_valid_nxt = 1'b0;

      case (state)
         ST_HDR: begin
            if (accept) begin
               hdr_keep_nxt  = hdr_mask;
               hdr_data_nxt  = data_m & expand(hdr_mask);
               hdr_valid_nxt = (s_in != '0);
               if (last_in) begin
                  // Single-beat packet: only bytes beyond the header are payload
                  if (n_in > s_in) begin
                     data_out_nxt  = first_rest;
                     keep_out_nxt  = top_ones(n_in - s_in);
                     last_out_nxt  = 1'b1;
                     valid_out_nxt = 1'b1;
                  end
               end else begin
                  res_data_nxt = first_rest;
                  res_cnt_nxt  = n_in - s_in;
                  state_nxt    = ST_BODY;
               end
            end
         end

         ST_BODY: begin
            if (accept) begin
               valid_out_nxt = 1'b1;
               data_out_nxt  = joined[2*DW-1 -: DW];
               res_data_nxt  = joined[DW-1:0];
               res_cnt_nxt   = (total > TW'(W)) ? CW'(total - TW'(W)) : '0;
               if (!last_in) begin
                  keep_out_nxt = '1;
                  last_out_nxt = 1'b0;
               end else if (total > TW'(W)) begin
                  keep_out_nxt = '1;
                  last_out_nxt = 1'b0;
                  state_nxt    = ST_FLUSH;
               end else begin
                  keep_out_nxt = top_ones(CW'(total));
                  last_out_nxt = 1'b1;
                  state_nxt    = ST_HDR;
               end
            end
         end

         ST_FLUSH: begin
            if (~valid_out | ready_out) begin
               data_out_nxt  = res_data;
               keep_out_nxt  = top_ones(res_cnt);
               last_out_nxt  = 1'b1;
               valid_out_nxt = 1'b1;
               res_data_nxt  = '0;
               res_cnt_nxt   = '0;
               state_nxt     = ST_HDR;
            end
         end

         default: state_nxt = ST_HDR;
      endcase
   end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header (W=4): directed packets, random
// packets with backpressure, mid-packet reset; scoreboard built from byte queues.
module tb_axi_stream_strip_header;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] data_in = '0;
   logic [3:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [2:0]  hdr_len = '0;
   logic [31:0] hdr_data;
   logic [3:0]  hdr_keep;
   logic        hdr_valid;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        valid_out;
   logic        ready_out = 1'b1;

   axi_stream_strip_header #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .valid_in(valid_in), .ready_in(ready_in), .hdr_len(hdr_len),
      .hdr_data(hdr_data), .hdr_keep(hdr_keep), .hdr_valid(hdr_valid),
      .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .valid_out(valid_out), .ready_out(ready_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
   typedef struct packed {logic [31:0] d; logic [3:0] k;} hdr_t;

   beat_t       exp_q[$];
   hdr_t        hexp_q[$];
   logic [7:0]  pkt[$];
   int          checks = 0;
   int          errors = 0;
   bit          bp = 1'b0;
   int          stall_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_d;
   logic [3:0]  prev_k;
   logic        prev_l;
   bit          dummy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: header = first min(S, first-beat bytes); payload = rest, in 4-byte chunks
   task automatic model_packet(input int hl);
      int s, len, first, hn, p;
      hdr_t  h;
      beat_t b;
      s     = (hl > 4) ? 4 : hl;
      len   = pkt.size();
      first = (len < 4) ? len : 4;
      hn    = (s < first) ? s : first;
      if (s > 0) begin
         h = '0;
         for (int i = 0; i < hn; i++) begin
            h.d[31-8*i -: 8] = pkt[i];
            h.k[3-i] = 1'b1;
         end
         hexp_q.push_back(h);
      end
      p = hn;
      while (p < len) begin
         b = '0;
         for (int j = 0; j < 4; j++)
            if (p + j < len) begin
               b.d[31-8*j -: 8] = pkt[p+j];
               b.k[3-j] = 1'b1;
            end
         b.l = (p + 4 >= len);
         exp_q.push_back(b);
         p += 4;
      end
   endtask

   // Observes the cycle about to be clocked: handshakes, header strobe, hold rules
   task automatic monitor();
      beat_t b;
      hdr_t  h;
      if (prev_stall) begin
         chk("hold_valid", 32'(valid_out), 32'd1);
         chk("hold_data", data_out, prev_d);
         chk("hold_keep", 32'(keep_out), 32'(prev_k));
         chk("hold_last", 32'(last_out), 32'(prev_l));
      end
      if (valid_out && !ready_out) chk("stall_ready_in", 32'(ready_in), 32'd0);
      if (hdr_valid) begin
         if (hexp_q.size() == 0) chk("hdr_unexpected", 32'(hdr_valid), 32'd0);
         else begin
            h = hexp_q.pop_front();
            chk("hdr_data", hdr_data, h.d);
            chk("hdr_keep", 32'(hdr_keep), 32'(h.k));
         end
      end
      if (valid_out && ready_out) begin
         if (exp_q.size() == 0) chk("beat_unexpected", 32'(valid_out), 32'd0);
         else begin
            b = exp_q.pop_front();
            chk("out_data", data_out, b.d);
            chk("out_keep", 32'(keep_out), 32'(b.k));
            chk("out_last", 32'(last_out), 32'(b.l));
         end
      end
      prev_stall = valid_out && !ready_out;
      prev_d = data_out;
      prev_k = keep_out;
      prev_l = last_out;
   endtask

   task automatic step(input bit v, input logic [31:0] d, input logic [3:0] k,
                       input bit l, input logic [2:0] hl, output bit acc);
      @(negedge clk);
      if (stall_cnt > 0) begin
         ready_out = 1'b0;
         stall_cnt--;
      end else if (bp) ready_out = ($urandom_range(0, 3) != 0);
      else ready_out = 1'b1;
      valid_in = v;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      hdr_len  = hl;
      #1;
      monitor();
      acc = v && ready_in;
   endtask

   task automatic idle();
      step(1'b0, $urandom, 4'h0, 1'b0, 3'h0, dummy);
   endtask

   task automatic send_packet(input int hl, input int stall_beat);
      int          len, nb, guard;
      logic [31:0] d;
      logic [3:0]  k;
      logic [2:0]  hlv;
      bit          acc;
      model_packet(hl);
      len = pkt.size();
      nb  = (len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         d = $urandom;
         k = '0;
         for (int j = 0; j < 4; j++)
            if (b*4 + j < len) begin
               d[31-8*j -: 8] = pkt[b*4+j];
               k[3-j] = 1'b1;
            end
         // hdr_len must only matter on the first beat
         hlv = (b == 0) ? 3'(hl) : 3'($urandom_range(0, 7));
         if (b == stall_beat) stall_cnt = 3;
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 100) begin
            if (bp && $urandom_range(0, 3) == 0) idle();
            else step(1'b1, d, k, (b == nb - 1), hlv, acc);
            guard++;
         end
         if (!acc) begin
            chk("accept_timeout", 32'(ready_in), 32'd1);
            return;
         end
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || hexp_q.size() != 0) && g < 200) begin
         idle();
         g++;
      end
      chk("drain_left", 32'(exp_q.size() + hexp_q.size()), 32'd0);
      repeat (3) idle();
   endtask

   task automatic fill_random(input int len);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values while rst is held low
      #12;
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_keep_out", 32'(keep_out), 32'd0);
      chk("rst_last_out", 32'(last_out), 32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_hdr_data", hdr_data, 32'd0);
      chk("rst_hdr_keep", 32'(hdr_keep), 32'd0);
      chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
      chk("rst_ready_in", 32'(ready_in), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Full-width header, one payload beat
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_packet(4, -1);
      drain();

      // One-byte header: realign across beats, then a flush beat
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_packet(1, -1);
      idle();
      chk("flush_ready_in", 32'(ready_in), 32'd0);
      drain();

      // Two-byte header, short last beat folds into one output beat
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_packet(2, -1);
      idle();
      chk("noflush_ready_in", 32'(ready_in), 32'd1);
      drain();

      // No header: pass-through, no strobe
      pkt = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
      send_packet(0, -1);
      drain();

      // Oversized hdr_len clamps to the full beat
      pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_packet(7, -1);
      drain();

      // Downstream stall for three cycles mid-packet
      fill_random(24);
      send_packet(1, 2);
      drain();

      // Random packets with random valid gaps and ready_out backpressure
      bp = 1'b1;
      for (int p = 0; p < 40; p++) begin
         fill_random($urandom_range(1, 14));
         send_packet($urandom_range(0, 7), -1);
      end
      drain();
      bp = 1'b0;

      // Mid-packet reset: partial packet dropped, next beat treated as a first beat
      hexp_q.push_back('{d: 32'hAABB0000, k: 4'hC});
      step(1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 3'd2, dummy);
      idle();
      step(1'b1, 32'h01020304, 4'hF, 1'b0, 3'd5, dummy);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_data_out", data_out, 32'd0);
      chk("arst_keep_out", 32'(keep_out), 32'd0);
      chk("arst_last_out", 32'(last_out), 32'd0);
      chk("arst_valid_out", 32'(valid_out), 32'd0);
      chk("arst_hdr_data", hdr_data, 32'd0);
      chk("arst_hdr_keep", 32'(hdr_keep), 32'd0);
      chk("arst_hdr_valid", 32'(hdr_valid), 32'd0);
      chk("arst_ready_in", 32'(ready_in), 32'd0);
      @(negedge clk);
      valid_in   = 1'b0;
      rst        = 1'b1;
      prev_stall = 1'b0;
      pkt = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3};
      send_packet(3, -1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
